// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device,
// ack check and whole-transfer timeout. Lines are driven open-drain via pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state_reg;
    logic [1:0]      c_filt_reg;
    logic            c_level_reg;
    logic            c_level_next;
    logic            fall;
    logic [1:0]      d_sync_reg;
    logic [8:0]      shift_reg;
    logic [3:0]      n_reg;
    logic [CW-1:0]   cnt_reg;
    logic            ps2c_oe_reg;
    logic            ps2d_oe_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;

    // Level only changes after two agreeing samples, so single-cycle glitches are absorbed.
    always_comb begin
        c_level_next = c_level_reg;
        if (c_filt_reg == 2'b11)
            c_level_next = 1'b1;
        else if (c_filt_reg == 2'b00)
            c_level_next = 1'b0;
    end

    assign fall = c_level_reg & ~c_level_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_filt_reg  <= 2'b00;
            c_level_reg <= 1'b0;
        end else begin
            c_filt_reg  <= {ps2c_in, c_filt_reg[1]};
            c_level_reg <= c_level_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dsync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) d_sync_reg[gi] <= 1'b0;
                    else     d_sync_reg[gi] <= ps2d_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) d_sync_reg[gi] <= 1'b0;
                    else     d_sync_reg[gi] <= d_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            n_reg       <= '0;
            cnt_reg     <= '0;
            ps2c_oe_reg <= 1'b0;
            ps2d_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (state_reg != IDLE && state_reg != RTS && cnt_reg == TO_LAST) begin
                // One budget for the whole frame, measured from clock release
                ps2c_oe_reg <= 1'b0;
                ps2d_oe_reg <= 1'b0;
                err_reg     <= 1'b1;
                state_reg   <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        busy_reg    <= 1'b0;
                        ps2c_oe_reg <= 1'b0;
                        ps2d_oe_reg <= 1'b0;
                        if (wr_ps2 && !busy_reg) begin
                            shift_reg   <= {~^din, din};
                            n_reg       <= '0;
                            cnt_reg     <= '0;
                            ps2c_oe_reg <= 1'b1;
                            busy_reg    <= 1'b1;
                            state_reg   <= RTS;
                        end
                    end
                    RTS: begin
                        if (cnt_reg == INH_LAST) begin
                            ps2c_oe_reg <= 1'b0;
                            ps2d_oe_reg <= 1'b1;
                            cnt_reg     <= '0;
                            state_reg   <= START;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg == INH_PRE)
                                ps2d_oe_reg <= 1'b1;
                        end
                    end
                    START: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (fall) begin
                            ps2d_oe_reg <= ~shift_reg[0];
                            n_reg       <= '0;
                            state_reg   <= DATA;
                        end
                    end
                    DATA: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (fall) begin
                            if (n_reg == 4'd8) begin
                                ps2d_oe_reg <= 1'b0;
                                state_reg   <= STOP;
                            end else begin
                                shift_reg   <= shift_reg >> 1;
                                ps2d_oe_reg <= ~shift_reg[1];
                                n_reg       <= n_reg + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        cnt_reg     <= cnt_reg + 1'b1;
                        ps2d_oe_reg <= 1'b0;
                        if (fall) begin
                            if (!d_sync_reg[1]) begin
                                state_reg <= WAIT_IDLE;
                            end else begin
                                err_reg   <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (c_filt_reg[0] && d_sync_reg[1]) begin
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign ps2c_oe      = ps2c_oe_reg;
    assign ps2d_oe      = ps2d_oe_reg;
    assign busy         = busy_reg;
    assign tx_done_tick = done_reg;
    assign tx_err_tick  = err_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host and captures bits.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TO   = 200;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_ps2;
    logic [7:0] din;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       tx_done_tick;
    logic       tx_err_tick;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .wr_ps2(wr_ps2), .din(din),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .busy(busy),
        .tx_done_tick(tx_done_tick), .tx_err_tick(tx_err_tick)
    );

    // Wired-AND open-drain lines
    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_data & ~ps2d_oe;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (tx_done_tick) done_cnt++;
        if (tx_err_tick) err_cnt++;
        if (tx_done_tick && tx_err_tick) both_cnt++;
    end

    typedef struct {
        logic [7:0] din;
        bit         ack;
        bit         glitch;
        bit         noise;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dev_pulse(input bit glitch, output logic smp);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        smp = ps2d_in;
        dev_clk = 1'b1;
        if (glitch) begin
            repeat (HALF/2) @(negedge clk);
            dev_clk = 1'b0;
            @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF - HALF/2 - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic start_write(input logic [7:0] b);
        int k;
        @(negedge clk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = 8'h00;
        k = 0;
        while (ps2c_oe && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("release_bound", 32'd1, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch, input bit noise,
                             output logic [9:0] bits, output int dd, output int de);
        int d0;
        int e0;
        int k;
        logic s;
        d0 = done_cnt;
        e0 = err_cnt;
        bits = '0;
        start_write(b);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) begin
                dev_data = 1'b0;
                repeat (4) @(negedge clk);
            end
            if (noise && i == 5) begin
                din = 8'h00;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
            dev_pulse(glitch && i <= 10, s);
            if (i <= 10) bits[i-1] = s;
        end
        dev_data = 1'b1;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("idle_bound", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int dd;
        int de;
        int k;
        logic s;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
        vecs[4] = '{8'hED, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[5] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0};

        rst = 1'b1;
        wr_ps2 = 1'b0;
        din = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, ps2c_oe, ps2d_oe, busy, tx_done_tick | tx_err_tick}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].din, vecs[v].ack, vecs[v].glitch, vecs[v].noise, bits, dd, de);
            check($sformatf("v%0d_data", v), {24'd0, bits[7:0]}, {24'd0, vecs[v].din});
            check($sformatf("v%0d_parity", v), {31'd0, bits[8]}, {31'd0, vecs[v].exp_par});
            check($sformatf("v%0d_stop", v), {31'd0, bits[9]}, 32'd1);
            check($sformatf("v%0d_done", v), dd, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), de, vecs[v].exp_err);
            check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            $display("[TB] frame din=%02h ack=%0d glitch=%0d noise=%0d bits=%03h done=%0d err=%0d",
                     vecs[v].din, vecs[v].ack, vecs[v].glitch, vecs[v].noise, bits, dd, de);
        end

        // Device never clocks: inhibit length, start bit, then timeout from clock release
        @(negedge clk);
        din = 8'hFF;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("latency_c_oe", {31'd0, ps2c_oe}, 32'd1);
        k = 0;
        while (ps2c_oe && k < 1000) begin
            k++;
            @(negedge clk);
        end
        check("inhibit_len", k, INH);
        check("start_bit_d_oe", {31'd0, ps2d_oe}, 32'd1);
        k = 0;
        while (!tx_err_tick && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_busy", {31'd0, busy}, 32'd1);
        check("timeout_no_done", {31'd0, tx_done_tick}, 32'd0);
        @(negedge clk);
        check("timeout_release", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        $display("[TB] timeout test: err after %0d cycles", k);
        repeat (3) @(negedge clk);

        // Reset mid-frame after bit 4 is driven, then a clean 0xF4
        start_write(8'hED);
        for (int i = 1; i <= 5; i++) dev_pulse(1'b0, s);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release", {29'd0, ps2c_oe, ps2d_oe, busy}, 32'd0);
        rst = 1'b0;
        $display("[TB] mid-frame reset: c_oe=%0d d_oe=%0d busy=%0d", ps2c_oe, ps2d_oe, busy);
        repeat (5) @(negedge clk);
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, bits, dd, de);
        check("f4_data", {24'd0, bits[7:0]}, 32'h0000_00F4);
        check("f4_parity", {31'd0, bits[8]}, 32'd0);
        check("f4_stop", {31'd0, bits[9]}, 32'd1);
        check("f4_done", dd, 32'd1);
        check("f4_err", de, 32'd0);
        $display("[TB] frame din=f4 after reset bits=%03h done=%0d err=%0d", bits, dd, de);

        check("never_both_ticks", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
